// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU front end: PC FSM states,
// jump-field encodings and the bit positions of the jump conditions.
package hack_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP_JMP  = 3'b111;

  localparam int JLT = 2;
  localparam int JEQ = 1;
  localparam int JGT = 0;

endpackage

// File: rtl/jump_cond.sv
// Combinational Hack jump-condition evaluator: take is high when the
// current C-instruction's jump bits select the ALU result's relation to zero.
module jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jmp,
  input  logic       is_c,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  logic [2:0] cond;

  // zr and ng are mutually exclusive for a real ALU, so exactly one
  // relation holds; GT is the case where neither flag is raised.
  assign cond[JLT] = ng;
  assign cond[JEQ] = zr;
  assign cond[JGT] = ~ng & ~zr;

  assign take = is_c & (|(jmp & cond));

endmodule

// File: rtl/pc_unit.sv
// Hack program counter: INIT/RUN/HALT FSM, jump evaluation and fetch handshake.
// Optional taken-jump counter on port jump_count when PC_TRACE_EN is defined.
module pc_unit
  import hack_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RST_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [2:0]       jmp,
  input  logic             is_c,
  input  logic             zr,
  input  logic             ng,
  input  logic             instr_valid,
  input  logic             stall,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_en,
  output logic             halted
`ifdef PC_TRACE_EN
  ,
  output logic [15:0]      jump_count
`endif
);

  pc_state_t        state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             take;
  logic             advance;
  logic             self_loop;

  jump_cond u_jump_cond (
    .jmp  (jmp),
    .is_c (is_c),
    .zr   (zr),
    .ng   (ng),
    .take (take)
  );

  assign advance   = (state_reg == RUN) & instr_valid & ~stall;
  // Canonical end-of-program idiom: unconditional jump to the current address.
  assign self_loop = advance & is_c & (jmp == JMP_JMP) & (a_in == pc_reg);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      INIT: state_next = RUN;
      RUN: begin
        if (advance) begin
          if (take) pc_next = a_in;
          else      pc_next = pc_reg + WIDTH'(1);
          if (self_loop) state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      pc_reg    <= RST_ADDR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign pc       = pc_reg;
  assign fetch_en = (state_reg == RUN);
  assign halted   = (state_reg == HALT);

`ifdef PC_TRACE_EN
  logic [15:0] jump_count_reg;
  logic        count_inc;

  // The halting jump is itself a taken jump, so it is counted too.
  assign count_inc = advance & take;

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_count_reg <= '0;
    end else if (count_inc && (jump_count_reg != 16'hFFFF)) begin
      jump_count_reg <= jump_count_reg + 16'd1;
    end
  end

  assign jump_count = jump_count_reg;
`endif

endmodule
